// File: rtl/piso_serializer_pkg.sv
// Shared types for the serial-link blocks (this serializer and future deserializers).
// Holds the frame FSM state encoding and a counter-width helper.
package piso_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Frame-position counter width; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load/shift interface of the serializer: producer (master) side and serializer (slave) side.
// Handshake: a word on d transfers at a clock edge where load_valid and load_ready are both high.
interface piso_serializer_if
   import piso_serializer_pkg::*;
#(
   parameter int W = 8
) ();
   localparam int CW = cnt_width(W);

   logic [W-1:0]  d;
   logic          load_valid;
   logic          load_ready;
   logic          shift_en;
   logic          ser_in;
   logic          ser_out;
   logic          busy;
   logic [CW-1:0] bit_idx;
   logic          done;
   ser_state_t    state;

   modport master (
      output d, load_valid, shift_en, ser_in,
      input  load_ready, ser_out, busy, bit_idx, done, state
   );

   modport slave (
      input  d, load_valid, shift_en, ser_in,
      output load_ready, ser_out, busy, bit_idx, done, state
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out frame serializer: captures a W-bit word on the load handshake,
// then emits one bit per shift_en strobe (LSB- or MSB-first) and pulses done after the last.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int   W          = 8,
   parameter int   MSB_FIRST  = 0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   piso_serializer_if.slave   bus
);
   localparam int            CW   = cnt_width(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   ser_state_t    state_q;
   logic [W-1:0]  q_q;
   logic [W-1:0]  shift_d;
   logic [CW-1:0] cnt_q;
   logic          done_q;

   // Fill bits enter the vacated end; they only become visible downstream via chaining.
   assign shift_d = (MSB_FIRST != 0) ? {q_q[W-2:0], bus.ser_in}
                                     : {bus.ser_in, q_q[W-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.load_valid) begin
                  q_q     <= bus.d;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (bus.shift_en) begin
                  q_q <= shift_d;
                  if (cnt_q == LAST) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.load_ready = (state_q == IDLE);
   assign bus.busy       = (state_q == SHIFT);
   assign bus.bit_idx    = cnt_q;
   assign bus.done       = done_q;
   assign bus.state      = state_q;
   assign bus.ser_out    = (state_q == SHIFT) ? ((MSB_FIRST != 0) ? q_q[W-1] : q_q[0])
                                              : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first (idle 0) and an MSB-first (idle 1) instance share
// stimulus; a frame-level model (word, bits consumed) predicts every output each cycle.
module tb_piso_serializer;
   import piso_serializer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Frame-level reference model
   bit         busy_m = 1'b0;
   bit         done_m = 1'b0;
   logic [7:0] w_m    = '0;
   int         k_m    = 0;

   piso_serializer_if #(.W(8)) ifa ();
   piso_serializer_if #(.W(8)) ifb ();

   piso_serializer #(.W(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa.slave));
   piso_serializer #(.W(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb.slave));

   always #5 clk = ~clk;

   function automatic logic [6:0] obs_a();
      return {ifa.load_ready, ifa.busy, ifa.bit_idx, ifa.ser_out, ifa.done};
   endfunction

   function automatic logic [6:0] obs_b();
      return {ifb.load_ready, ifb.busy, ifb.bit_idx, ifb.ser_out, ifb.done};
   endfunction

   function automatic logic [6:0] exp_obs(input bit msb, input logic idle_lvl);
      logic sb;
      if (busy_m) sb = msb ? w_m[7 - k_m] : w_m[k_m];
      else        sb = idle_lvl;
      return {~busy_m, busy_m, 3'(k_m), sb, done_m};
   endfunction

   task automatic model_reset();
      busy_m = 1'b0;
      done_m = 1'b0;
      k_m    = 0;
   endtask

   // Drive one cycle of stimulus to both instances, advance the model, sample at edge+1.
   task automatic tick(input logic lv, input logic [7:0] dv, input logic se);
      logic si;
      si = 1'($urandom_range(0, 1));
      ifa.load_valid = lv; ifb.load_valid = lv;
      ifa.d          = dv; ifb.d          = dv;
      ifa.shift_en   = se; ifb.shift_en   = se;
      ifa.ser_in     = si; ifb.ser_in     = ~si;
      @(posedge clk);
      done_m = 1'b0;
      if (!busy_m) begin
         if (lv) begin
            busy_m = 1'b1;
            w_m    = dv;
            k_m    = 0;
         end
      end else if (se) begin
         if (k_m == 7) begin
            busy_m = 1'b0;
            done_m = 1'b1;
            k_m    = 0;
         end else begin
            k_m = k_m + 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
      ifa.d = '0; ifb.d = '0;
      ifa.shift_en = 1'b0; ifb.shift_en = 1'b0;
      ifa.ser_in = 1'b0; ifb.ser_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (obs_a() !== 7'b1000000) begin
         n_bad++; $display("FAIL reset_a got %b exp %b", obs_a(), 7'b1000000);
      end
      n_cmp++;
      if (obs_b() !== 7'b1000010) begin
         n_bad++; $display("FAIL reset_b got %b exp %b", obs_b(), 7'b1000010);
      end
      n_cmp++;
      if (ifa.state !== IDLE) begin
         n_bad++; $display("FAIL reset_state got %0d exp %0d", ifa.state, IDLE);
      end
      reset = 1'b0;
      tick(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (obs_a() !== exp_obs(0, 1'b0)) begin
         n_bad++; $display("FAIL idle_shift_a got %b exp %b", obs_a(), exp_obs(0, 1'b0));
      end
   endtask

   task automatic test_lsb_stream();
      logic [7:0] got;
      got = '0;
      tick(1'b1, 8'b1011_0000, 1'b1);   // load wins over the simultaneous strobe
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (obs_a() !== exp_obs(0, 1'b0)) begin
            n_bad++; $display("FAIL lsb_a bit %0d got %b exp %b", i, obs_a(), exp_obs(0, 1'b0));
         end
         n_cmp++;
         if (obs_b() !== exp_obs(1, 1'b1)) begin
            n_bad++; $display("FAIL lsb_b bit %0d got %b exp %b", i, obs_b(), exp_obs(1, 1'b1));
         end
         got[i] = ifa.ser_out;
         tick(1'b0, 8'h00, 1'b1);
      end
      n_cmp++;
      if (obs_a() !== exp_obs(0, 1'b0) || ifa.done !== 1'b1) begin
         n_bad++; $display("FAIL lsb_done got %b exp %b", obs_a(), exp_obs(0, 1'b0));
      end
      n_cmp++;
      if (got !== 8'b1011_0000) begin
         n_bad++; $display("FAIL lsb_stream got %b exp %b", got, 8'b1011_0000);
      end
      tick(1'b0, 8'h00, 1'b0);
      n_cmp++;
      if (ifa.done !== 1'b0 || ifb.done !== 1'b0) begin
         n_bad++; $display("FAIL done_width got %b%b exp 00", ifa.done, ifb.done);
      end
   endtask

   task automatic test_msb_stride3();
      logic [7:0] got;
      got = '0;
      tick(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 8; i++) begin
         for (int s = 0; s < 3; s++) begin
            if (s == 0) got[7 - i] = ifb.ser_out;
            n_cmp++;
            if (obs_b() !== exp_obs(1, 1'b1)) begin
               n_bad++; $display("FAIL msb_b bit %0d s %0d got %b exp %b", i, s, obs_b(), exp_obs(1, 1'b1));
            end
            n_cmp++;
            if (obs_a() !== exp_obs(0, 1'b0)) begin
               n_bad++; $display("FAIL msb_a bit %0d s %0d got %b exp %b", i, s, obs_a(), exp_obs(0, 1'b0));
            end
            tick(1'b0, 8'h00, s == 2);
         end
      end
      n_cmp++;
      if (obs_b() !== exp_obs(1, 1'b1) || ifb.done !== 1'b1) begin
         n_bad++; $display("FAIL msb_done got %b exp %b", obs_b(), exp_obs(1, 1'b1));
      end
      n_cmp++;
      if (got !== 8'hA5) begin
         n_bad++; $display("FAIL msb_stream got %h exp %h", got, 8'hA5);
      end
      tick(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_back_to_back();
      int busy_cycles;
      busy_cycles = 0;
      tick(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (ifa.busy === 1'b1) busy_cycles++;
         n_cmp++;
         if (obs_a() !== exp_obs(0, 1'b0)) begin
            n_bad++; $display("FAIL b2b_a cyc %0d got %b exp %b", i, obs_a(), exp_obs(0, 1'b0));
         end
         n_cmp++;
         if (obs_b() !== exp_obs(1, 1'b1)) begin
            n_bad++; $display("FAIL b2b_b cyc %0d got %b exp %b", i, obs_b(), exp_obs(1, 1'b1));
         end
         tick(i < 9, 8'h00, 1'b1);
      end
      n_cmp++;
      if (busy_cycles != 16) begin
         n_bad++; $display("FAIL b2b_busy_cycles got %0d exp 16", busy_cycles);
      end
   endtask

   task automatic test_load_ignored();
      logic [7:0] got;
      got = '0;
      tick(1'b1, 8'hC3, 1'b0);
      for (int i = 0; i < 8; i++) begin
         got[i] = ifa.ser_out;
         n_cmp++;
         if (obs_a() !== exp_obs(0, 1'b0) || ifa.load_ready !== 1'b0) begin
            n_bad++; $display("FAIL ignore_a bit %0d got %b exp %b", i, obs_a(), exp_obs(0, 1'b0));
         end
         n_cmp++;
         if (obs_b() !== exp_obs(1, 1'b1)) begin
            n_bad++; $display("FAIL ignore_b bit %0d got %b exp %b", i, obs_b(), exp_obs(1, 1'b1));
         end
         if (i == 2 || i == 3) tick(1'b1, 8'h3C, 1'b0);
         tick(i == 3, 8'h3C, 1'b1);
      end
      n_cmp++;
      if (got !== 8'hC3) begin
         n_bad++; $display("FAIL ignore_stream got %h exp %h", got, 8'hC3);
      end
      tick(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_abort();
      logic [7:0] got;
      got = '0;
      tick(1'b1, 8'h5A, 1'b0);
      repeat (3) tick(1'b0, 8'h00, 1'b1);
      reset = 1'b1;
      #2;
      model_reset();
      n_cmp++;
      if (obs_a() !== 7'b1000000) begin
         n_bad++; $display("FAIL abort_a got %b exp %b", obs_a(), 7'b1000000);
      end
      n_cmp++;
      if (obs_b() !== 7'b1000010) begin
         n_bad++; $display("FAIL abort_b got %b exp %b", obs_b(), 7'b1000010);
      end
      #1 reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 8'h00, 1'b1);
         n_cmp++;
         if (obs_a() !== exp_obs(0, 1'b0)) begin
            n_bad++; $display("FAIL abort_nodone cyc %0d got %b exp %b", i, obs_a(), exp_obs(0, 1'b0));
         end
      end
      tick(1'b1, 8'h81, 1'b0);
      for (int i = 0; i < 8; i++) begin
         got[i] = ifa.ser_out;
         n_cmp++;
         if (obs_a() !== exp_obs(0, 1'b0)) begin
            n_bad++; $display("FAIL reload_a bit %0d got %b exp %b", i, obs_a(), exp_obs(0, 1'b0));
         end
         tick(1'b0, 8'h00, 1'b1);
      end
      n_cmp++;
      if (got !== 8'h81 || ifa.done !== 1'b1) begin
         n_bad++; $display("FAIL reload_stream got %h done %b exp %h done 1", got, ifa.done, 8'h81);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         tick($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
         n_cmp++;
         if (obs_a() !== exp_obs(0, 1'b0)) begin
            n_bad++; $display("FAIL rand_a cyc %0d got %b exp %b", i, obs_a(), exp_obs(0, 1'b0));
         end
         n_cmp++;
         if (obs_b() !== exp_obs(1, 1'b1)) begin
            n_bad++; $display("FAIL rand_b cyc %0d got %b exp %b", i, obs_b(), exp_obs(1, 1'b1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_lsb_stream();
      test_msb_stride3();
      test_back_to_back();
      test_load_ignored();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
